// File: rtl/mem_pkg.sv
// Shared definitions for the memory-control LDR/STR path and the RAM-side responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } resp_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [3:0] OP_LDR = 4'b1001;
  localparam logic [3:0] OP_STR = 4'b1010;

  // Wait-state counter is 4 bits wide.
  localparam int WAIT_MAX = 15;

  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> addr_w) != 32'd0;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM with registered read data.
module ram_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/data_ram_responder.sv
// RAM-side responder: accepts one word request, waits WAIT_CYCLES, accesses the array, pulses Ready.
module data_ram_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              Req,
  input  logic              RW_In,
  input  logic [31:0]       AddressIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Ready,
  output logic              Busy,
  output logic              AddrErr
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
      $error("data_ram_responder: WAIT_CYCLES must be within 0..15");
    end
  endgenerate

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  resp_state_t       state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic              oor_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] dout_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              req_oor;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign req_oor = addr_out_of_range(AddressIn, ADDR_W);

  // The RAM read is registered, so the address must be presented on the edge entering ACCESS;
  // with zero wait states that edge is the accept edge itself, hence the live address in IDLE.
  assign ram_addr = (state_q == IDLE) ? AddressIn[ADDR_W-1:0] : addr_q;
  assign ram_we   = (state_q == ACCESS) && EN && (rw_q == RW_WRITE) && !oor_q;

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (EN && Req) begin
            addr_q  <= AddressIn[ADDR_W-1:0];
            rw_q    <= RW_In;
            oor_q   <= req_oor;
            wdata_q <= DataIn;
            cnt_q   <= WAIT_INIT;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (!EN) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!EN) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (rw_q == RW_READ) begin
              dout_q <= oor_q ? '0 : ram_rdata;
            end
            err_q   <= oor_q;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DataOut = dout_q;
  assign Ready   = ready_q;
  assign Busy    = busy_q;
  assign AddrErr = err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Two responders (2 and 0 wait states) share one stimulus stream; a transaction-level model feeds a scoreboard.
module tb_data_ram_responder;

  localparam int   NDUT = 2;
  localparam logic RD   = 1'b1;
  localparam logic WR   = 1'b0;

  logic        clk = 1'b0;
  logic        rst, en, req, rw;
  logic [31:0] addr, din;
  logic [31:0] dout [NDUT];
  logic        rdy  [NDUT];
  logic        bsy  [NDUT];
  logic        aerr [NDUT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .EN(en), .Req(req), .RW_In(rw), .AddressIn(addr), .DataIn(din),
    .DataOut(dout[0]), .Ready(rdy[0]), .Busy(bsy[0]), .AddrErr(aerr[0])
  );

  data_ram_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .EN(en), .Req(req), .RW_In(rw), .AddressIn(addr), .DataIn(din),
    .DataOut(dout[1]), .Ready(rdy[1]), .Busy(bsy[1]), .AddrErr(aerr[1])
  );

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return a >= 32'd256;
  endfunction

  // ---------------- reference model: one outstanding access per responder ----------------
  typedef struct {
    int          dut;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    bit          known;
    int          rdy_edge;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mem_m      [NDUT][256];
  bit          known_m    [NDUT][256];
  bit          busy_m     [NDUT];
  int          acc_m      [NDUT];
  bit          pend_rw    [NDUT];
  logic [31:0] pend_addr  [NDUT];
  logic [31:0] pend_data  [NDUT];
  logic [31:0] dout_m     [NDUT];
  bit          dout_known [NDUT];
  int          edge_cnt = 0;

  function automatic int find_exp(input int k);
    foreach (sb[i]) if (sb[i].dut == k) return i;
    return -1;
  endfunction

  task automatic model_accept(input int k);
    exp_t e;
    acc_m[k]     = edge_cnt;
    busy_m[k]    = 1'b1;
    pend_rw[k]   = rw;
    pend_addr[k] = addr;
    pend_data[k] = din;
    e.dut  = k;
    e.rw   = rw;
    e.addr = addr;
    e.err  = oor(addr);
    if (rw == RD) begin
      e.data  = oor(addr) ? 32'd0 : mem_m[k][addr[7:0]];
      e.known = oor(addr) || known_m[k][addr[7:0]];
    end else begin
      e.data  = din;
      e.known = 1'b1;
    end
    // Ready is observed during the cycle after the access edge (accept + wait states + 1).
    e.rdy_edge = edge_cnt + wc(k) + 1;
    sb.push_back(e);
  endtask

  task automatic model_commit(input int k);
    logic [31:0] a;
    a = pend_addr[k];
    if (pend_rw[k] == WR) begin
      if (!oor(a)) begin
        mem_m[k][a[7:0]]   = pend_data[k];
        known_m[k][a[7:0]] = 1'b1;
      end
    end else if (oor(a)) begin
      dout_m[k]     = 32'd0;
      dout_known[k] = 1'b1;
    end else begin
      dout_m[k]     = mem_m[k][a[7:0]];
      dout_known[k] = known_m[k][a[7:0]];
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < NDUT; k++) begin
        busy_m[k]     = 1'b0;
        dout_m[k]     = 32'd0;
        dout_known[k] = 1'b1;
      end
      sb.delete();
      return;
    end
    edge_cnt++;
    for (int k = 0; k < NDUT; k++) begin
      if (busy_m[k]) begin
        if (edge_cnt <= acc_m[k] + wc(k) + 1) begin
          if (!en) begin
            int i;
            i = find_exp(k);
            busy_m[k] = 1'b0;
            if (i >= 0) sb.delete(i);
            $display("[TB] dut%0d (W=%0d) %s addr=%h abandoned: EN low at edge %0d",
                     k, wc(k), pend_rw[k] ? "LDR" : "STR", pend_addr[k], edge_cnt);
          end else if (edge_cnt == acc_m[k] + wc(k) + 1) begin
            model_commit(k);
          end
        end else begin
          busy_m[k] = 1'b0;
        end
      end else if (en && req) begin
        model_accept(k);
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_edge();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d (W=%0d): got %h, required %h (edge %0d)",
               name, k, wc(k), act, exp, edge_cnt);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst !== 1'b0) continue;
    for (int k = 0; k < NDUT; k++) begin
      int   i;
      exp_t e;
      chk("busy", k, 32'(bsy[k]), 32'(busy_m[k]));
      if (dout_known[k]) chk("dataout_hold", k, dout[k], dout_m[k]);
      i = find_exp(k);
      if (rdy[k] === 1'b1) begin
        if (i < 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_ready dut%0d (W=%0d): got Ready=1, required 0 (edge %0d)",
                   k, wc(k), edge_cnt);
        end else begin
          e = sb[i];
          sb.delete(i);
          chk("ready_latency", k, 32'(edge_cnt), 32'(e.rdy_edge));
          chk("addrerr", k, 32'(aerr[k]), 32'(e.err));
          if (e.rw == RD && e.known) chk("read_data", k, dout[k], e.data);
          $display("[TB] dut%0d (W=%0d) %s addr=%h data=%h err=%0d ready at edge %0d",
                   k, wc(k), e.rw ? "LDR" : "STR", e.addr, dout[k], aerr[k], edge_cnt);
        end
      end else begin
        chk("addrerr_without_ready", k, 32'(aerr[k]), 32'd0);
        if (i >= 0 && sb[i].rdy_edge <= edge_cnt) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL missing_ready dut%0d (W=%0d): got Ready=0, required 1 (edge %0d)",
                   k, wc(k), edge_cnt);
          sb.delete(i);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_m[0] || busy_m[1]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  // After the accept edge the request fields are scrambled (alt_a, opposite RW) so that
  // anything sampled after accept shows up as a wrong access.
  task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input int en_drop, input logic [31:0] alt_a);
    wait_idle();
    rw = r; addr = a; din = d; req = 1'b1; en = 1'b1;
    @(negedge clk);
    rw = ~r; addr = alt_a; din = $urandom;
    for (int c = 1; c <= 4; c++) begin
      req = (c <= hold);
      en  = (c != en_drop);
      @(negedge clk);
    end
    req = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; req = 1'b0; rw = WR; addr = 32'd0; din = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_dataout", k, dout[k], 32'd0);
      chk("reset_ready", k, 32'(rdy[k]), 32'd0);
      chk("reset_busy", k, 32'(bsy[k]), 32'd0);
      chk("reset_addrerr", k, 32'(aerr[k]), 32'd0);
    end

    for (int a = 0; a < 16; a++) issue(WR, 32'(a), $urandom, 0, 0, 32'h0);
    issue(WR, 32'hFF, 32'hFEEDF00D, 0, 0, 32'h0);
    issue(RD, 32'hFF, 32'h0, 0, 0, 32'h0);

    // Write then read back with the expected latency.
    issue(WR, 32'h05, 32'hDEADBEEF, 0, 0, 32'h0);
    issue(RD, 32'h05, 32'h0, 0, 0, 32'h0);

    // Req held continuously: each responder re-accepts on the edge after DONE.
    wait_idle();
    rw = RD; addr = 32'h05; req = 1'b1;
    repeat (10) @(negedge clk);
    req = 1'b0;

    // Out-of-range accesses.
    issue(WR, 32'h100, 32'h00001234, 0, 0, 32'h0);
    issue(RD, 32'h00, 32'h0, 0, 0, 32'h0);
    issue(RD, 32'h100, 32'h0, 0, 0, 32'h0);
    issue(RD, 32'hFFFF_FF05, 32'h0, 0, 0, 32'h0);

    // Req held while busy with a different address must be ignored.
    issue(WR, 32'h07, 32'h77777777, 0, 0, 32'h0);
    issue(RD, 32'h05, 32'h0, 2, 0, 32'h07);
    issue(RD, 32'h07, 32'h0, 0, 0, 32'h0);

    // EN dropped during WAIT / ACCESS.
    issue(WR, 32'h09, 32'h5A5A0000, 0, 0, 32'h0);
    issue(WR, 32'h09, 32'hA5A5A5A5, 0, 1, 32'h0);
    issue(RD, 32'h09, 32'h0, 0, 0, 32'h0);
    issue(WR, 32'h0A, 32'h0A0A0A0A, 0, 3, 32'h0);
    issue(RD, 32'h0A, 32'h0, 0, 0, 32'h0);

    // EN low in IDLE blocks requests.
    issue(WR, 32'h03, 32'h33333333, 0, 0, 32'h0);
    wait_idle();
    en = 1'b0; req = 1'b1; rw = WR; addr = 32'h03; din = 32'hCAFE0003;
    repeat (3) @(negedge clk);
    req = 1'b0; en = 1'b1;
    issue(RD, 32'h03, 32'h0, 0, 0, 32'h0);

    // Asynchronous reset between edges while a write is in flight.
    wait_idle();
    rw = WR; addr = 32'h05; din = 32'h11111111; req = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    req = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("async_reset_dataout", k, dout[k], 32'd0);
      chk("async_reset_ready", k, 32'(rdy[k]), 32'd0);
      chk("async_reset_busy", k, 32'(bsy[k]), 32'd0);
      chk("async_reset_addrerr", k, 32'(aerr[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(RD, 32'h05, 32'h0, 0, 0, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      int          sel;
      int          hold;
      int          drop;
      sel = $urandom_range(0, 9);
      if (sel < 7)      a = 32'($urandom_range(0, 15));
      else if (sel < 8) a = 32'($urandom_range(16, 255));
      else              a = $urandom | 32'h100;
      hold = $urandom_range(0, 2);
      drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      issue(1'($urandom_range(0, 1)), a, $urandom, hold, drop, 32'($urandom_range(0, 15)));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
